// File: rtl/sev_seg_pkg.sv
// Shared constants and the hex font for the seven-segment scan driver.
// All glyphs are active-low and ordered {g,f,e,d,c,b,a}.
package sev_seg_pkg;

  localparam int N_DIGITS = 4;

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_R     = 7'b0101111;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;

  // Hex digit to segment pattern; 6 and 9 are drawn with their tails.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sev_seg_scan_if.sv
// Bundle of the display-side signals of the scan driver.
// Handshake: there is no valid/ready pair here; load is a single-cycle
// strobe that is sampled on every rising clk edge and captures
// nib_lo/nib_hi/src_reg when high. Display outputs are free-running.
interface sev_seg_scan_if;
  logic       en;
  logic       load;
  logic [3:0] nib_lo;
  logic [3:0] nib_hi;
  logic       src_reg;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_idx;

  modport master (
    output en, load, nib_lo, nib_hi, src_reg,
    input  an, seg, dp, digit_idx
  );

  modport slave (
    input  en, load, nib_lo, nib_hi, src_reg,
    output an, seg, dp, digit_idx
  );
endinterface

// File: rtl/sev_seg_scan_hex_to_seg.sv
// Combinational hex-to-segment decoder wrapping the package font.
module hex_to_seg
  import sev_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = hex_font(i_nib);

endmodule

// File: rtl/sev_seg_scan.sv
// Four-digit common-anode scan driver: digit 3 shows the source glyph,
// digit 2 is blank, digits 1/0 show the captured high/low nibble.
// Each slot opens with a blanking window to stop ghosting between digits.
module sev_seg_scan
  import sev_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic           clk,
  input  logic           rst,
  sev_seg_scan_if.slave  bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);

  logic [PW-1:0]       r_pcnt;
  logic [1:0]          r_digit;
  logic [3:0]          r_hold_lo;
  logic [3:0]          r_hold_hi;
  logic                r_hold_src;
  logic [N_DIGITS-1:0] r_an;
  logic [6:0]          r_seg;

  logic [3:0]          w_nib;
  logic [6:0]          w_hex;
  logic [6:0]          w_glyph;
  logic [N_DIGITS-1:0] w_an;
  logic                w_blank;

  // Capture the display word on the load strobe; independent of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_lo  <= 4'h0;
      r_hold_hi  <= 4'h0;
      r_hold_src <= 1'b0;
    end else if (bus.load) begin
      r_hold_lo  <= bus.nib_lo;
      r_hold_hi  <= bus.nib_hi;
      r_hold_src <= bus.src_reg;
    end
  end

  // Prescaler and digit counter; both freeze while the display is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt  <= '0;
      r_digit <= 2'd0;
    end else if (bus.en) begin
      if (r_pcnt == P_LAST) begin
        r_pcnt  <= '0;
        r_digit <= r_digit + 2'd1;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end
    end
  end

  // Only digit 1 needs the high nibble; the decoder is shared.
  assign w_nib = (r_digit == 2'd1) ? r_hold_hi : r_hold_lo;

  hex_to_seg u_hex (
    .i_nib (w_nib),
    .o_seg (w_hex)
  );

  // Select the glyph for the current slot and decode its anode.
  always_comb begin
    w_an          = '1;
    w_an[r_digit] = 1'b0;
    case (r_digit)
      2'd0, 2'd1: w_glyph = w_hex;
      2'd2:       w_glyph = GLYPH_BLANK;
      default:    w_glyph = r_hold_src ? GLYPH_R : GLYPH_D;
    endcase
  end

  assign w_blank = !bus.en || (r_pcnt < P_BLANK);

  // Registered drive so anode and segment lines switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst || w_blank) begin
      r_an  <= '1;
      r_seg <= GLYPH_BLANK;
    end else begin
      r_an  <= w_an;
      r_seg <= w_glyph;
    end
  end

  assign bus.an        = r_an;
  assign bus.seg       = r_seg;
  assign bus.dp        = 1'b1;
  assign bus.digit_idx = r_digit;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Self-checking bench for sev_seg_scan with REFRESH_DIV=8, BLANK_CYC=2.
module tb_sev_seg_scan;

  localparam int DIV = 8;
  localparam int BLK = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sev_seg_scan_if bus ();

  sev_seg_scan #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] font [16];
  initial begin
    font[0]  = 7'b1000000; font[1]  = 7'b1111001; font[2]  = 7'b0100100; font[3]  = 7'b0110000;
    font[4]  = 7'b0011001; font[5]  = 7'b0010010; font[6]  = 7'b0000010; font[7]  = 7'b1111000;
    font[8]  = 7'b0000000; font[9]  = 7'b0010000; font[10] = 7'b0001000; font[11] = 7'b0000011;
    font[12] = 7'b1000110; font[13] = 7'b0100001; font[14] = 7'b0000110; font[15] = 7'b0001110;
  end

  int         m_cycle;   // cycle count since reset: slot and position derive from it
  logic [3:0] m_lo, m_hi;
  logic       m_src;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  function automatic logic [6:0] slot_glyph(input int d);
    case (d)
      0:       return font[m_lo];
      1:       return font[m_hi];
      2:       return 7'b1111111;
      default: return m_src ? 7'b0101111 : 7'b0100001;
    endcase
  endfunction

  // The model counts enabled cycles; slot = (count / DIV) mod 4, offset = count mod DIV.
  always @(posedge clk) begin
    if (rst) begin
      m_cycle = 0; m_lo = 0; m_hi = 0; m_src = 0;
      m_an = 4'hF; m_seg = 7'h7F;
    end else begin
      if (!bus.en || (m_cycle % DIV) < BLK) begin
        m_an = 4'hF; m_seg = 7'h7F;
      end else begin
        m_an  = 4'hF & ~(4'h1 << ((m_cycle / DIV) % 4));
        m_seg = slot_glyph((m_cycle / DIV) % 4);
      end
      if (bus.load) begin m_lo = bus.nib_lo; m_hi = bus.nib_hi; m_src = bus.src_reg; end
      if (bus.en) m_cycle = (m_cycle + 1) % (4 * DIV);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_an", bus.an, m_an);
      check("model_seg", bus.seg, m_seg);
      check("model_dp", bus.dp, 1);
      check("model_idx", bus.digit_idx, (m_cycle / DIV) % 4);
      check("one_anode", ($countones(~bus.an) <= 1), 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_load(input logic [3:0] lo, input logic [3:0] hi, input logic src);
    bus.nib_lo = lo; bus.nib_hi = hi; bus.src_reg = src; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic sync_to_slot(input logic [1:0] d);
    logic [1:0] prev;
    bit found;
    found = 1'b0;
    prev  = bus.digit_idx;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.digit_idx == d && prev != d) found = 1'b1;
      prev = bus.digit_idx;
    end
    check("sync_found", found, 1);
  endtask

  // Starts on the sample where digit_idx has just become 0; ends on the
  // sample where it becomes 0 again, 32 cycles later.
  task automatic walk_frame(input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] es [4];
    logic [3:0] ea [4];
    es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
    ea[0] = 4'b1110; ea[1] = 4'b1101; ea[2] = 4'b1011; ea[3] = 4'b0111;
    for (int s = 0; s < 4; s++) begin
      for (int j = 1; j <= 8; j++) begin
        @(negedge clk);
        if (j <= 2) begin
          check("blank_an", bus.an, 4'b1111);
          check("blank_seg", bus.seg, 7'b1111111);
        end else begin
          check("slot_an", bus.an, ea[s]);
          check("slot_seg", bus.seg, es[s]);
        end
      end
      check("slot_advance", bus.digit_idx, (s + 1) % 4);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1; bus.en = 1'b1; bus.load = 1'b0;
    bus.nib_lo = 4'h0; bus.nib_hi = 4'h0; bus.src_reg = 1'b0;
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    check("por_an", bus.an, 4'b1111);
    check("por_seg", bus.seg, 7'b1111111);
    rst = 1'b0;

    // Reset mid-scan, with load also high (reset wins)
    repeat (11) @(negedge clk);
    rst = 1'b1; bus.load = 1'b1; bus.nib_lo = 4'h7;
    repeat (3) @(negedge clk);
    check("rst_an", bus.an, 4'b1111);
    check("rst_seg", bus.seg, 7'b1111111);
    check("rst_dp", bus.dp, 1);
    check("rst_idx", bus.digit_idx, 0);
    rst = 1'b0; bus.load = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (bus.an != 4'hF) break;
    end
    check("first_active_wait", n, 3);
    check("first_active_an", bus.an, 4'b1110);
    check("first_active_seg", bus.seg, 7'b1000000);

    // Load and a full frame
    pulse_load(4'hA, 4'h3, 1'b1);
    sync_to_slot(2'd0);
    walk_frame(7'b0001000, 7'b0110000, 7'b1111111, 7'b0101111);

    // Input change without load must not show
    bus.nib_lo = 4'h5;
    walk_frame(7'b0001000, 7'b0110000, 7'b1111111, 7'b0101111);

    // Enable drop mid slot 1
    sync_to_slot(2'd1);
    repeat (3) @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("dis_an", bus.an, 4'b1111);
      check("dis_idx", bus.digit_idx, 1);
    end
    bus.en = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) check("resume_an", bus.an, 4'b1101);
      if (bus.digit_idx == 2'd2) break;
    end
    check("resume_remaining", n, 5);

    // Load coincident with the wrap into slot 0
    sync_to_slot(2'd3);
    repeat (7) @(negedge clk);
    bus.nib_lo = 4'hF; bus.src_reg = 1'b0; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    check("wrap_idx", bus.digit_idx, 0);
    walk_frame(7'b0001110, 7'b0110000, 7'b1111111, 7'b0100001);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
